// File: rtl/div_unit.sv
// Multi-cycle restoring integer divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow finish on a single-cycle fast path.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             finish_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE_VAL;
  endfunction

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dsr_r;
  logic             q_neg_r;
  logic             r_neg_r;

  logic             dvd_neg_s;
  logic             dsr_neg_s;
  logic [WIDTH-1:0] dvd_mag_s;
  logic [WIDTH-1:0] dsr_mag_s;
  logic             div_zero_s;
  logic             overflow_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] step_rem_s;
  logic [WIDTH-1:0] step_dvd_s;

  // Operand magnitudes, special-case detection and one restoring step.
  always_comb begin
    dvd_neg_s  = signed_i & dividend_i[WIDTH-1];
    dsr_neg_s  = signed_i & divisor_i[WIDTH-1];
    dvd_mag_s  = dividend_i;
    dsr_mag_s  = divisor_i;
    if (dvd_neg_s) begin
      dvd_mag_s = negate(dividend_i);
    end else begin
      dvd_mag_s = dividend_i;
    end
    if (dsr_neg_s) begin
      dsr_mag_s = negate(divisor_i);
    end else begin
      dsr_mag_s = divisor_i;
    end
    div_zero_s = (divisor_i == {WIDTH{1'b0}});
    overflow_s = signed_i && (dividend_i == MIN_VAL) && (divisor_i == {WIDTH{1'b1}});

    // Borrow out of the WIDTH+1-bit trial subtraction means the divisor did not fit.
    shifted_s  = {rem_r, dvd_r[WIDTH-1]};
    trial_s    = shifted_s - {1'b0, dsr_r};
    step_rem_s = shifted_s[WIDTH-1:0];
    step_dvd_s = {dvd_r[WIDTH-2:0], 1'b0};
    if (!trial_s[WIDTH]) begin
      step_rem_s = trial_s[WIDTH-1:0];
      step_dvd_s = {dvd_r[WIDTH-2:0], 1'b1};
    end else begin
      step_rem_s = shifted_s[WIDTH-1:0];
      step_dvd_s = {dvd_r[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM, working registers and registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      dvd_r       <= {WIDTH{1'b0}};
      dsr_r       <= {WIDTH{1'b0}};
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      busy_o      <= 1'b0;
      finish_o    <= 1'b0;
      quotient_o  <= {WIDTH{1'b0}};
      remainder_o <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            if (div_zero_s) begin
              quotient_o  <= {WIDTH{1'b1}};
              remainder_o <= dividend_i;
              finish_o    <= 1'b1;
              state_r     <= DONE;
            end else if (overflow_s) begin
              quotient_o  <= MIN_VAL;
              remainder_o <= {WIDTH{1'b0}};
              finish_o    <= 1'b1;
              state_r     <= DONE;
            end else begin
              dvd_r   <= dvd_mag_s;
              dsr_r   <= dsr_mag_s;
              rem_r   <= {WIDTH{1'b0}};
              q_neg_r <= dvd_neg_s ^ dsr_neg_s;
              r_neg_r <= dvd_neg_s;
              cnt_r   <= CW'(WIDTH);
              busy_o  <= 1'b1;
              state_r <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          rem_r <= step_rem_s;
          dvd_r <= step_dvd_s;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r <= SIGN;
          end else begin
            state_r <= CALC;
          end
        end
        SIGN: begin
          quotient_o  <= q_neg_r ? negate(dvd_r) : dvd_r;
          remainder_o <= r_neg_r ? negate(rem_r) : rem_r;
          busy_o      <= 1'b0;
          finish_o    <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          finish_o <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          busy_o   <= 1'b0;
          finish_o <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases plus randomized operands
// against an arithmetic reference model, at WIDTH=32 and WIDTH=8.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        start, sgn;
  logic [31:0] dvd, dsr;
  logic        busy, finish;
  logic [31:0] q, r;

  logic        start8, sgn8;
  logic [7:0]  dvd8, dsr8;
  logic        busy8, finish8;
  logic [7:0]  q8, r8;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .signed_i(sgn),
    .dividend_i(dvd), .divisor_i(dsr), .busy_o(busy), .finish_o(finish),
    .quotient_o(q), .remainder_o(r)
  );

  div_unit #(.WIDTH(8)) dut8 (
    .clk_i(clk), .reset_i(reset), .start_i(start8), .signed_i(sgn8),
    .dividend_i(dvd8), .divisor_i(dsr8), .busy_o(busy8), .finish_o(finish8),
    .quotient_o(q8), .remainder_o(r8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: C-style truncating division on widened integers.
  function automatic void model32(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eq, output logic [31:0] er, output int elat);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF; er = a; elat = 0;
    end else begin
      sa = s ? longint'($signed(a)) : longint'({32'd0, a});
      sb = s ? longint'($signed(b)) : longint'({32'd0, b});
      lq = sa / sb;
      lr = sa % sb;
      eq = lq[31:0];
      er = lr[31:0];
      elat = (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 0 : 33;
    end
  endfunction

  function automatic void model8(input logic s, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] eq, output logic [7:0] er, output int elat);
    int sa, sb, iq, ir;
    if (b == 8'd0) begin
      eq = 8'hFF; er = a; elat = 0;
    end else begin
      sa = s ? int'($signed(a)) : int'({24'd0, a});
      sb = s ? int'($signed(b)) : int'({24'd0, b});
      iq = sa / sb;
      ir = sa % sb;
      eq = iq[7:0];
      er = ir[7:0];
      elat = (s && a == 8'h80 && b == 8'hFF) ? 0 : 9;
    end
  endfunction

  // One request on the 32-bit unit; lat = negedges after accept until finish (-1 on timeout).
  task automatic run32(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] oq, output logic [31:0] orr,
                       output int lat, output int busy_cnt);
    @(negedge clk);
    sgn = s; dvd = a; dsr = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; dvd = $urandom; dsr = $urandom; sgn = 1'($urandom_range(0, 1));
    lat = -1; busy_cnt = 0; oq = 32'd0; orr = 32'd0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (finish) begin
        lat = k; oq = q; orr = r;
        break;
      end
    end
  endtask

  task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] oq, output logic [7:0] orr, output int lat);
    @(negedge clk);
    sgn8 = s; dvd8 = a; dsr8 = b; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0; dvd8 = 8'($urandom); dsr8 = 8'($urandom);
    lat = -1; oq = 8'd0; orr = 8'd0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (finish8) begin
        lat = k; oq = q8; orr = r8;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; sgn = 1'b0; dvd = 32'd0; dsr = 32'd0;
    start8 = 1'b0; sgn8 = 1'b0; dvd8 = 8'd0; dsr8 = 8'd0;
    #1;
    checks++;
    if ({busy, finish, q, r} !== 66'd0) begin
      errors++; $display("FAIL reset32 got busy=%b fin=%b q=%h r=%h, want all 0", busy, finish, q, r);
    end
    checks++;
    if ({busy8, finish8, q8, r8} !== 18'd0) begin
      errors++; $display("FAIL reset8 got busy=%b fin=%b q=%h r=%h, want all 0", busy8, finish8, q8, r8);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_unsigned;
    logic [31:0] oq, orr;
    int lat, bc;
    run32(1'b0, 32'd100, 32'd7, oq, orr, lat, bc);
    checks++;
    if (oq !== 32'd14 || orr !== 32'd2) begin
      errors++; $display("FAIL udiv_100_7 got q=%0d r=%0d, want q=14 r=2", oq, orr);
    end
    checks++;
    if (lat !== 33) begin
      errors++; $display("FAIL udiv_latency got %0d, want 33", lat);
    end
    checks++;
    if (bc !== 33) begin
      errors++; $display("FAIL udiv_busy_cycles got %0d, want 33", bc);
    end
    @(negedge clk);
    checks++;
    if (finish !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL finish_single_pulse got fin=%b busy=%b, want 0 0", finish, busy);
    end
  endtask

  task automatic test_signed;
    logic [31:0] oq, orr;
    int lat, bc;
    run32(1'b1, 32'hFFFF_FFF9, 32'd2, oq, orr, lat, bc);
    checks++;
    if (oq !== 32'hFFFF_FFFD || orr !== 32'hFFFF_FFFF || lat !== 33) begin
      errors++; $display("FAIL sdiv_m7_2 got q=%h r=%h lat=%0d, want q=fffffffd r=ffffffff lat=33", oq, orr, lat);
    end
    run32(1'b1, 32'd7, 32'hFFFF_FFFE, oq, orr, lat, bc);
    checks++;
    if (oq !== 32'hFFFF_FFFD || orr !== 32'd1 || lat !== 33) begin
      errors++; $display("FAIL sdiv_7_m2 got q=%h r=%h lat=%0d, want q=fffffffd r=1 lat=33", oq, orr, lat);
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] oq, orr;
    int lat, bc;
    for (int s = 0; s < 2; s++) begin
      run32(1'(s), 32'd5, 32'd0, oq, orr, lat, bc);
      checks++;
      if (oq !== 32'hFFFF_FFFF || orr !== 32'd5 || lat !== 0 || bc !== 0) begin
        errors++;
        $display("FAIL div_zero s=%0d got q=%h r=%h lat=%0d busy=%0d, want q=ffffffff r=5 lat=0 busy=0",
                 s, oq, orr, lat, bc);
      end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] oq, orr;
    int lat, bc;
    run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, oq, orr, lat, bc);
    checks++;
    if (oq !== 32'h8000_0000 || orr !== 32'd0 || lat !== 0) begin
      errors++; $display("FAIL sdiv_overflow got q=%h r=%h lat=%0d, want q=80000000 r=0 lat=0", oq, orr, lat);
    end
    run32(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, oq, orr, lat, bc);
    checks++;
    if (oq !== 32'd0 || orr !== 32'h8000_0000 || lat !== 33) begin
      errors++; $display("FAIL udiv_min_allones got q=%h r=%h lat=%0d, want q=0 r=80000000 lat=33", oq, orr, lat);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] oq, orr;
    int lat, bc;
    @(negedge clk);
    sgn = 1'b0; dvd = 32'd1000; dsr = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_before_reset got %b, want 1", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, finish, q, r} !== 66'd0) begin
      errors++; $display("FAIL reset_mid_calc got busy=%b fin=%b q=%h r=%h, want all 0", busy, finish, q, r);
    end
    @(negedge clk);
    reset = 1'b0;
    run32(1'b0, 32'd9, 32'd3, oq, orr, lat, bc);
    checks++;
    if (oq !== 32'd3 || orr !== 32'd0 || lat !== 33) begin
      errors++; $display("FAIL after_reset_9_3 got q=%0d r=%0d lat=%0d, want q=3 r=0 lat=33", oq, orr, lat);
    end
  endtask

  task automatic test_back_to_back;
    int pulses, first, second;
    logic [31:0] q1, r1, q2, r2, hq, hr;
    pulses = 0; first = -1; second = -1;
    q1 = 32'd0; r1 = 32'd0; q2 = 32'd0; r2 = 32'd0; hq = 32'd0; hr = 32'd0;
    @(negedge clk);
    sgn = 1'b0; dvd = 32'd50; dsr = 32'd5; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (finish) begin
        pulses++;
        if (first < 0) begin
          first = k; q1 = q; r1 = r;
        end else begin
          second = k; q2 = q; r2 = r;
        end
      end
      if (k == 34) dvd = 32'd51;
      if (k == 35) start = 1'b0;
      if (k == 50) begin
        hq = q; hr = r;
      end
    end
    checks++;
    if (pulses !== 2 || first !== 33 || second !== 68) begin
      errors++; $display("FAIL b2b_pulses got n=%0d at %0d,%0d, want n=2 at 33,68", pulses, first, second);
    end
    checks++;
    if (q1 !== 32'd10 || r1 !== 32'd0 || q2 !== 32'd10 || r2 !== 32'd1) begin
      errors++; $display("FAIL b2b_results got %0d/%0d then %0d/%0d, want 10/0 then 10/1", q1, r1, q2, r2);
    end
    checks++;
    if (hq !== 32'd10 || hr !== 32'd0) begin
      errors++; $display("FAIL b2b_hold got q=%0d r=%0d, want q=10 r=0", hq, hr);
    end
  endtask

  task automatic test_random32;
    logic [31:0] a, b, oq, orr, eq, er;
    logic s;
    int lat, bc, elat;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      model32(s, a, b, eq, er, elat);
      run32(s, a, b, oq, orr, lat, bc);
      checks++;
      if (oq !== eq || orr !== er || lat !== elat) begin
        errors++;
        $display("FAIL rand32 s=%0d %h/%h got q=%h r=%h lat=%0d, want q=%h r=%h lat=%0d",
                 s, a, b, oq, orr, lat, eq, er, elat);
      end
    end
  endtask

  task automatic test_width8;
    logic [7:0] a, b, oq, orr, eq, er;
    logic s;
    int lat, elat;
    run8(1'b0, 8'd200, 8'd3, oq, orr, lat);
    checks++;
    if (oq !== 8'd66 || orr !== 8'd2 || lat !== 9) begin
      errors++; $display("FAIL w8_200_3 got q=%0d r=%0d lat=%0d, want q=66 r=2 lat=9", oq, orr, lat);
    end
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom);
      b = (i % 7 == 0) ? 8'd0 : ((i % 7 == 1) ? 8'hFF : 8'($urandom));
      if (i % 7 == 2) a = 8'h80;
      s = 1'($urandom_range(0, 1));
      model8(s, a, b, eq, er, elat);
      run8(s, a, b, oq, orr, lat);
      checks++;
      if (oq !== eq || orr !== er || lat !== elat) begin
        errors++;
        $display("FAIL rand8 s=%0d %h/%h got q=%h r=%h lat=%0d, want q=%h r=%h lat=%0d",
                 s, a, b, oq, orr, lat, eq, er, elat);
      end
    end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_overflow;
    test_back_to_back;
    test_reset_mid;
    test_random32;
    test_width8;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
